// File: rtl/swim_cmd_ctrl_if.sv
// rtl/swim_cmd_ctrl_if.sv - host byte stream, status stream and SWIM engine handshake bundle
interface swim_cmd_ctrl_if;
    logic [7:0] cmd_data;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] rsp_data;
    logic       rsp_valid;
    logic       rsp_ready;
    logic       swim_low;
    logic       entry_start;
    logic       entry_done;
    logic       tx_start;
    logic [7:0] tx_byte;
    logic       tx_done;
    logic       tx_nack;
    logic       busy;

    // Controller side
    modport master (
        input  cmd_data, cmd_valid, rsp_ready, entry_done, tx_done, tx_nack,
        output cmd_ready, rsp_data, rsp_valid, swim_low, entry_start,
               tx_start, tx_byte, busy
    );

    // Host / line-engine side
    modport slave (
        output cmd_data, cmd_valid, rsp_ready, entry_done, tx_done, tx_nack,
        input  cmd_ready, rsp_data, rsp_valid, swim_low, entry_start,
               tx_start, tx_byte, busy
    );
endinterface

// File: rtl/swim_cmd_ctrl.sv
// rtl/swim_cmd_ctrl.sv - SWIM command sequencer: parses host bytes, drives entry/tx engines, returns status
module swim_cmd_ctrl #(
    parameter int LOW_CYC     = 9600,
    parameter int TIMEOUT_CYC = 480000,
    parameter int TW          = 20
) (
    input  logic          clk,
    input  logic          reset,
    swim_cmd_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_LEN,
        S_GET_DATA,
        S_LINE_LOW,
        S_ENTRY_WAIT,
        S_TX_WAIT,
        S_RSP
    } state_t;

    localparam logic [TW-1:0] LOW_LAST     = TW'(LOW_CYC - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYC - 1);

    localparam logic [7:0] CMD_ENTRY = 8'h01;
    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] CMD_PING  = 8'h03;

    localparam logic [7:0] RSP_ENTRY_OK = 8'h81;
    localparam logic [7:0] RSP_WRITE_OK = 8'h82;
    localparam logic [7:0] RSP_PING_OK  = 8'h83;
    localparam logic [7:0] RSP_TIMEOUT  = 8'hE0;
    localparam logic [7:0] RSP_BAD_LEN  = 8'hE2;
    localparam logic [7:0] RSP_NACK     = 8'hE3;
    localparam logic [7:0] RSP_BAD_CMD  = 8'hEF;

    state_t         state;
    logic [TW-1:0]  cnt;
    logic [7:0]     remain;
    logic           cmd_ready_q;
    logic [7:0]     rsp_data_q;
    logic           rsp_valid_q;
    logic           swim_low_q;
    logic           entry_start_q;
    logic           tx_start_q;
    logic [7:0]     tx_byte_q;
    logic           busy_q;

    logic accept;
    logic timed_out;

    assign accept    = bus.cmd_valid && cmd_ready_q;
    assign timed_out = (cnt == TIMEOUT_LAST);

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.swim_low    = swim_low_q;
    assign bus.entry_start = entry_start_q;
    assign bus.tx_start    = tx_start_q;
    assign bus.tx_byte     = tx_byte_q;
    assign bus.busy        = busy_q;

    // Command sequencer: every output is a register updated alongside the state
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            cnt           <= '0;
            remain        <= '0;
            cmd_ready_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_valid_q   <= 1'b0;
            swim_low_q    <= 1'b0;
            entry_start_q <= 1'b0;
            tx_start_q    <= 1'b0;
            tx_byte_q     <= '0;
            busy_q        <= 1'b0;
        end else begin
            // Start strobes are single-cycle; the shared counter free-runs and saturates
            entry_start_q <= 1'b0;
            tx_start_q    <= 1'b0;
            if (!timed_out) begin
                cnt <= cnt + TW'(1);
            end

            case (state)
                S_IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (accept) begin
                        busy_q      <= 1'b1;
                        cmd_ready_q <= 1'b0;
                        case (bus.cmd_data)
                            CMD_ENTRY: begin
                                state      <= S_LINE_LOW;
                                cnt        <= '0;
                                swim_low_q <= 1'b1;
                            end
                            CMD_WRITE: begin
                                state       <= S_GET_LEN;
                                cmd_ready_q <= 1'b1;
                            end
                            CMD_PING: begin
                                state       <= S_RSP;
                                rsp_valid_q <= 1'b1;
                                rsp_data_q  <= RSP_PING_OK;
                            end
                            default: begin
                                state       <= S_RSP;
                                rsp_valid_q <= 1'b1;
                                rsp_data_q  <= RSP_BAD_CMD;
                            end
                        endcase
                    end
                end

                S_GET_LEN: begin
                    if (accept) begin
                        if (bus.cmd_data == 8'd0) begin
                            state       <= S_RSP;
                            cmd_ready_q <= 1'b0;
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= RSP_BAD_LEN;
                        end else begin
                            remain <= bus.cmd_data;
                            state  <= S_GET_DATA;
                        end
                    end
                end

                S_GET_DATA: begin
                    if (accept) begin
                        tx_byte_q   <= bus.cmd_data;
                        tx_start_q  <= 1'b1;
                        cnt         <= '0;
                        cmd_ready_q <= 1'b0;
                        state       <= S_TX_WAIT;
                    end
                end

                S_LINE_LOW: begin
                    if (cnt == LOW_LAST) begin
                        swim_low_q    <= 1'b0;
                        entry_start_q <= 1'b1;
                        cnt           <= '0;
                        state         <= S_ENTRY_WAIT;
                    end
                end

                S_ENTRY_WAIT: begin
                    // A done arriving on the timeout cycle still counts as success
                    if (bus.entry_done) begin
                        state       <= S_RSP;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= RSP_ENTRY_OK;
                    end else if (timed_out) begin
                        state       <= S_RSP;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= RSP_TIMEOUT;
                    end
                end

                S_TX_WAIT: begin
                    if (bus.tx_done) begin
                        if (bus.tx_nack) begin
                            // Leftover operands stay in the host stream and are parsed as commands
                            state       <= S_RSP;
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= RSP_NACK;
                        end else if (remain == 8'd1) begin
                            state       <= S_RSP;
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= RSP_WRITE_OK;
                        end else begin
                            remain      <= remain - 8'd1;
                            cmd_ready_q <= 1'b1;
                            state       <= S_GET_DATA;
                        end
                    end else if (timed_out) begin
                        state       <= S_RSP;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= RSP_TIMEOUT;
                    end
                end

                S_RSP: begin
                    // cmd_ready stays low here, guaranteeing an idle cycle before the next accept
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state       <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_swim_cmd_ctrl.sv
// tb/tb_swim_cmd_ctrl.sv - self-checking bench for swim_cmd_ctrl
module tb_swim_cmd_ctrl;

    localparam int LOW = 20;
    localparam int TO  = 300;

    typedef logic [7:0] bq_t[$];
    typedef bit         nq_t[$];

    typedef struct packed {
        logic [2:0][7:0] b;
        logic [1:0]      n;
        logic [7:0]      rsp;
        logic [1:0]      ntx;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    swim_cmd_ctrl_if bus();

    swim_cmd_ctrl #(.LOW_CYC(LOW), .TIMEOUT_CYC(TO), .TW(20)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Engine model controls
    int  entry_d     = 50;
    bit  entry_en    = 1'b1;
    int  tx_d        = 100;
    bit  tx_en       = 1'b1;
    bit  rand_mode   = 1'b0;
    bit  ready_level = 1'b1;
    nq_t nack_plan;

    // Observations
    bq_t got_rsp;
    bq_t got_tx;
    int  n_entry_start = 0;
    int  n_low         = 0;
    int  rise_cyc      = 0;
    int  hs_cyc        = 0;
    int  acc_cyc       = 0;
    bit  rv_prev       = 1'b0;

    // Entry and transmitter engines plus the response consumer
    initial begin
        int  ecd;
        int  tcd;
        bit  cur_nack;
        ecd = 0;
        tcd = 0;
        cur_nack = 1'b0;
        bus.entry_done = 1'b0;
        bus.tx_done    = 1'b0;
        bus.tx_nack    = 1'b0;
        bus.rsp_ready  = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.entry_done = 1'b0;
            bus.tx_done    = 1'b0;
            bus.tx_nack    = 1'b0;
            if (reset) begin
                ecd = 0;
                tcd = 0;
            end
            if (ecd > 0) begin
                ecd--;
                if (ecd == 0) bus.entry_done = 1'b1;
            end
            if (bus.entry_start && entry_en)
                ecd = rand_mode ? int'($urandom_range(1, 6)) : entry_d;
            if (tcd > 0) begin
                tcd--;
                if (tcd == 0) begin
                    bus.tx_done = 1'b1;
                    bus.tx_nack = cur_nack;
                end
            end
            if (bus.tx_start && tx_en) begin
                tcd = rand_mode ? int'($urandom_range(1, 8)) : tx_d;
                cur_nack = (nack_plan.size() > 0) ? nack_plan.pop_front() : 1'b0;
            end
            bus.rsp_ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_level;
        end
    end

    // Monitor sampled mid-cycle, away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            if (bus.rsp_valid && bus.rsp_ready) begin
                got_rsp.push_back(bus.rsp_data);
                hs_cyc = cyc;
            end
            if (bus.rsp_valid && !rv_prev) rise_cyc = cyc;
            rv_prev = bus.rsp_valid;
            if (bus.tx_start) got_tx.push_back(bus.tx_byte);
            if (bus.entry_start) n_entry_start++;
            if (bus.swim_low) n_low++;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_obs();
        got_rsp.delete();
        got_tx.delete();
        n_entry_start = 0;
        n_low = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit done;
        done = 1'b0;
        bus.cmd_data  = b;
        bus.cmd_valid = 1'b1;
        for (int k = 0; k < 2000 && !done; k++) begin
            @(negedge clk);
            if (bus.cmd_ready) begin
                done = 1'b1;
                acc_cyc = cyc;
            end
        end
        check($sformatf("accept_%02h", b), 32'(done), 32'd1);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsps(input int n, input int budget);
        for (int k = 0; k < budget && got_rsp.size() < n; k++) tick(1);
        check("rsp_count", got_rsp.size(), n);
    endtask

    function automatic logic [7:0] pop_rsp();
        return (got_rsp.size() > 0) ? got_rsp.pop_front() : 8'h00;
    endfunction

    function automatic logic [21:0] outs();
        return {bus.cmd_ready, bus.rsp_valid, bus.rsp_data, bus.swim_low,
                bus.entry_start, bus.tx_start, bus.tx_byte, bus.busy};
    endfunction

    // Reference: walk the host byte stream command by command
    function automatic void ref_model(input bq_t s, input nq_t plan, output bq_t rsp, output bq_t tx);
        int i;
        rsp.delete();
        tx.delete();
        i = 0;
        while (i < s.size()) begin
            logic [7:0] b;
            b = s[i];
            i++;
            if (b == 8'h01) rsp.push_back(8'h81);
            else if (b == 8'h03) rsp.push_back(8'h83);
            else if (b == 8'h02) begin
                int  len;
                int  sent;
                bit  nacked;
                if (i >= s.size()) break;
                len = int'(s[i]);
                i++;
                sent = 0;
                nacked = 1'b0;
                if (len == 0) rsp.push_back(8'hE2);
                else begin
                    while (sent < len && i < s.size() && !nacked) begin
                        tx.push_back(s[i]);
                        i++;
                        sent++;
                        if (plan.size() > 0 && plan.pop_front()) nacked = 1'b1;
                    end
                    if (nacked) rsp.push_back(8'hE3);
                    else if (sent == len) rsp.push_back(8'h82);
                end
            end else rsp.push_back(8'hEF);
        end
    endfunction

    function automatic vec_t mk(input logic [1:0] n, input logic [7:0] b0, input logic [7:0] b1,
                                input logic [7:0] b2, input logic [7:0] rsp, input logic [1:0] ntx);
        vec_t v;
        v.b[0] = b0;
        v.b[1] = b1;
        v.b[2] = b2;
        v.n    = n;
        v.rsp  = rsp;
        v.ntx  = ntx;
        return v;
    endfunction

    initial begin
        vec_t vecs[7];
        bq_t  s;
        nq_t  plan;
        bq_t  exp_rsp;
        bq_t  exp_tx;

        vecs[0] = mk(2'd1, 8'h03, 8'h00, 8'h00, 8'h83, 2'd0);
        vecs[1] = mk(2'd1, 8'h55, 8'h00, 8'h00, 8'hEF, 2'd0);
        vecs[2] = mk(2'd1, 8'h00, 8'h00, 8'h00, 8'hEF, 2'd0);
        vecs[3] = mk(2'd1, 8'hFF, 8'h00, 8'h00, 8'hEF, 2'd0);
        vecs[4] = mk(2'd2, 8'h02, 8'h00, 8'h00, 8'hE2, 2'd0);
        vecs[5] = mk(2'd3, 8'h02, 8'h01, 8'h5A, 8'h82, 2'd1);
        vecs[6] = mk(2'd1, 8'h01, 8'h00, 8'h00, 8'h81, 2'd0);

        bus.cmd_data  = 8'h00;
        bus.cmd_valid = 1'b0;

        // Reset state and cmd_ready release timing
        tick(3);
        check("reset_outputs", 32'(outs()), 32'd0);
        reset = 1'b0;
        check("ready_first_cycle", 32'(bus.cmd_ready), 32'd0);
        tick(1);
        check("ready_second_cycle", 32'(bus.cmd_ready), 32'd1);

        // Table-driven single commands
        entry_d = 3;
        tx_d    = 5;
        for (int v = 0; v < 7; v++) begin
            clear_obs();
            for (int j = 0; j < int'(vecs[v].n); j++) send_byte(vecs[v].b[j]);
            wait_rsps(1, 1000);
            check($sformatf("vec%0d_rsp", v), 32'(pop_rsp()), 32'(vecs[v].rsp));
            check($sformatf("vec%0d_ntx", v), got_tx.size(), 32'(vecs[v].ntx));
            tick(2);
            check($sformatf("vec%0d_busy", v), 32'(bus.busy), 32'd0);
            check($sformatf("vec%0d_extra_rsp", v), got_rsp.size(), 0);
        end

        // Entry: line low width, single start pulse, response latency
        entry_d = 50;
        clear_obs();
        send_byte(8'h01);
        wait_rsps(1, 1000);
        check("entry_rsp", 32'(pop_rsp()), 32'h81);
        check("entry_low_cycles", n_low, LOW);
        check("entry_start_pulses", n_entry_start, 1);
        check("entry_latency", rise_cyc - acc_cyc, LOW + 50 + 2);

        // Three-byte write
        tx_d = 100;
        clear_obs();
        send_byte(8'h02); send_byte(8'h03);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
        wait_rsps(1, 1000);
        check("write3_rsp", 32'(pop_rsp()), 32'h82);
        check("write3_ntx", got_tx.size(), 3);
        check("write3_tx0", 32'(got_tx.size() > 0 ? got_tx[0] : 8'h00), 32'hAA);
        check("write3_tx1", 32'(got_tx.size() > 1 ? got_tx[1] : 8'h00), 32'hBB);
        check("write3_tx2", 32'(got_tx.size() > 2 ? got_tx[2] : 8'h00), 32'hCC);

        // NACK on first operand; leftover operand is parsed as a command
        tx_d = 5;
        nack_plan.delete();
        nack_plan.push_back(1'b1);
        clear_obs();
        send_byte(8'h02); send_byte(8'h02); send_byte(8'h11);
        send_byte(8'h22);
        check("idle_gap_after_rsp", acc_cyc - hs_cyc, 2);
        wait_rsps(2, 1000);
        check("nack_rsp", 32'(pop_rsp()), 32'hE3);
        check("leftover_rsp", 32'(pop_rsp()), 32'hEF);
        check("nack_ntx", got_tx.size(), 1);

        // Entry timeout, then zero-length write
        entry_en = 1'b0;
        clear_obs();
        send_byte(8'h01);
        wait_rsps(1, LOW + TO + 50);
        check("entry_timeout_rsp", 32'(pop_rsp()), 32'hE0);
        check("entry_timeout_latency", rise_cyc - acc_cyc, LOW + TO + 1);
        entry_en = 1'b1;
        send_byte(8'h02); send_byte(8'h00);
        wait_rsps(1, 1000);
        check("zero_len_rsp", 32'(pop_rsp()), 32'hE2);

        // Transmitter timeout
        tx_en = 1'b0;
        clear_obs();
        send_byte(8'h02); send_byte(8'h01); send_byte(8'h33);
        wait_rsps(1, TO + 50);
        check("tx_timeout_rsp", 32'(pop_rsp()), 32'hE0);
        tx_en = 1'b1;

        // Reset during line-low phase
        clear_obs();
        send_byte(8'h01);
        tick(5);
        check("in_line_low", 32'(bus.swim_low), 32'd1);
        reset = 1'b1;
        tick(1);
        check("reset_line_low_outputs", 32'(outs()), 32'd0);
        reset = 1'b0;
        tick(1);
        check("ready_after_reset", 32'(bus.cmd_ready), 32'd1);
        tick(LOW + 10);
        check("no_entry_after_reset", n_entry_start, 0);
        check("no_rsp_after_reset", got_rsp.size(), 0);

        // Reset while a response is held
        ready_level = 1'b0;
        clear_obs();
        send_byte(8'h03);
        for (int k = 0; k < 50 && !bus.rsp_valid; k++) tick(1);
        check("rsp_held", 32'(bus.rsp_valid), 32'd1);
        tick(3);
        reset = 1'b1;
        tick(1);
        check("reset_rsp_outputs", 32'(outs()), 32'd0);
        reset = 1'b0;
        ready_level = 1'b1;
        tick(20);
        check("no_stale_rsp", got_rsp.size(), 0);
        check("idle_after_reset", 32'(bus.busy), 32'd0);

        // Randomized command streams against the reference model
        s.delete();
        plan.delete();
        for (int c = 0; c < 30; c++) begin
            int r;
            r = int'($urandom_range(0, 5));
            case (r)
                0: s.push_back(8'h01);
                1: s.push_back(8'h03);
                2: s.push_back(8'($urandom_range(16, 255)));
                3: begin s.push_back(8'h02); s.push_back(8'h00); end
                default: begin
                    int len;
                    len = int'($urandom_range(1, 4));
                    s.push_back(8'h02);
                    s.push_back(8'(len));
                    for (int d = 0; d < len; d++) s.push_back(8'($urandom_range(16, 255)));
                end
            endcase
        end
        for (int p = 0; p < 80; p++) plan.push_back($urandom_range(0, 3) == 0);
        ref_model(s, plan, exp_rsp, exp_tx);
        nack_plan = plan;
        rand_mode = 1'b1;
        clear_obs();
        for (int k = 0; k < s.size(); k++) begin
            send_byte(s[k]);
            tick(int'($urandom_range(0, 2)));
        end
        wait_rsps(exp_rsp.size(), 3000);
        for (int k = 0; k < exp_rsp.size(); k++)
            check($sformatf("rand_rsp%0d", k), 32'(k < got_rsp.size() ? got_rsp[k] : 8'h00), 32'(exp_rsp[k]));
        check("rand_ntx", got_tx.size(), exp_tx.size());
        for (int k = 0; k < exp_tx.size(); k++)
            check($sformatf("rand_tx%0d", k), 32'(k < got_tx.size() ? got_tx[k] : 8'h00), 32'(exp_tx[k]));
        rand_mode = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
